// File: rtl/result_packer_if.sv
// Result byte stream and SRAM write port shared by result_packer and its neighbours.
// wr_strb exists only when RESULT_PACKER_WSTRB_EN is defined.
interface result_packer_if #(
  parameter int RESULT_DWIDTH = 8,
  parameter int WORD_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10
);
  logic [RESULT_DWIDTH-1:0] result_data;
  logic                     result_valid;
  logic                     wr_en;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [WORD_WIDTH-1:0]    wr_data;
  logic                     wr_ready;
`ifdef RESULT_PACKER_WSTRB_EN
  logic [WORD_WIDTH/RESULT_DWIDTH-1:0] wr_strb;

  modport master (
    input  result_data, result_valid, wr_ready,
    output wr_en, wr_addr, wr_data, wr_strb
  );
  modport slave (
    output result_data, result_valid, wr_ready,
    input  wr_en, wr_addr, wr_data, wr_strb
  );
`else
  modport master (
    input  result_data, result_valid, wr_ready,
    output wr_en, wr_addr, wr_data
  );
  modport slave (
    output result_data, result_valid, wr_ready,
    input  wr_en, wr_addr, wr_data
  );
`endif
endinterface

// File: rtl/result_packer.sv
// Packs 8-bit results little-endian into words, buffers them, writes them to SRAM (RESULT_PACKER_WSTRB_EN adds wr_strb).
// Word visible on wr_en one cycle after its last byte; wr_ready stalls the FIFO head, a push into a full FIFO drops the word.
module rp_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A pop frees the slot on the same edge, so a full FIFO still accepts a push then.
  assign do_pop   = pop_vld && !empty;
  assign do_push  = push_vld && (!full || do_pop);
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module result_packer #(
  parameter int RESULT_DWIDTH = 8,
  parameter int WORD_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  frame_end,
  result_packer_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_ovrflow
);
  localparam int LANES = WORD_WIDTH / RESULT_DWIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

`ifdef RESULT_PACKER_WSTRB_EN
  localparam int FW = WORD_WIDTH + LANES;
`else
  localparam int FW = WORD_WIDTH;
`endif

  logic [1:0]            state;
  logic [LW-1:0]         lane;
  logic [WORD_WIDTH-1:0] pack_q;
  logic [WORD_WIDTH-1:0] pack_nxt;
  logic [WORD_WIDTH-1:0] flush_word;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  acc_vld;
  logic                  word_done;
  logic                  flush_push;
  logic                  push_vld;
  logic [FW-1:0]         push_dat;
  logic [FW-1:0]         head_dat;
  logic                  xfer;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign acc_vld    = (state == RUN) && bus.result_valid && !start;
  assign word_done  = acc_vld && (lane == LW'(LANES - 1));
  assign flush_push = (state == FLUSH) && (lane != '0) && !start;
  assign push_vld   = word_done || flush_push;
  assign xfer       = bus.wr_en && bus.wr_ready;

  always_comb begin
    pack_nxt = pack_q;
    pack_nxt[int'(lane)*RESULT_DWIDTH +: RESULT_DWIDTH] = bus.result_data;
    // Stale bytes from the previous word sit in the upper lanes; keep only filled lanes.
    flush_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(lane)) flush_word[i*RESULT_DWIDTH +: RESULT_DWIDTH] = pack_q[i*RESULT_DWIDTH +: RESULT_DWIDTH];
    end
  end

`ifdef RESULT_PACKER_WSTRB_EN
  logic [LANES-1:0] flush_strb;

  always_comb begin
    flush_strb = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(lane)) flush_strb[i] = 1'b1;
    end
  end

  assign push_dat    = flush_push ? {flush_strb, flush_word} : {{LANES{1'b1}}, pack_nxt};
  assign bus.wr_strb = head_dat[FW-1 -: LANES];
`else
  assign push_dat = flush_push ? flush_word : pack_nxt;
`endif

  rp_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (start),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (xfer),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.wr_en   = !fifo_empty;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = head_dat[WORD_WIDTH-1:0];
  assign busy        = (state == RUN) || (state == FLUSH);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      lane         <= '0;
      pack_q       <= '0;
      addr_q       <= '0;
      fifo_ovrflow <= 1'b0;
    end else if (start) begin
      state        <= RUN;
      lane         <= '0;
      addr_q       <= base_addr;
      fifo_ovrflow <= 1'b0;
    end else begin
      if (xfer) addr_q <= addr_q + 1'b1;
      if (push_vld && fifo_full && !xfer) fifo_ovrflow <= 1'b1;
      case (state)
        IDLE: ;
        RUN: begin
          if (acc_vld) begin
            pack_q <= pack_nxt;
            lane   <= word_done ? '0 : lane + 1'b1;
          end
          if (frame_end) state <= FLUSH;
        end
        FLUSH: begin
          if (lane != '0) lane <= '0;
          else if (fifo_empty) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/result_packer.md
Name: result_packer

Overview:
- Downstream of the convolution datapath; consumes its 8-bit result_data/result_valid stream.
- Packs consecutive results into 32-bit words, little-endian, and buffers them in a small FIFO.
- Writes the words to the output SRAM through a ready/valid write port, using an auto-incrementing word address.
- Handles frame start, end-of-frame flush of partial words and FIFO overflow reporting.

Parameters:
- RESULT_DWIDTH, 8, width of one incoming result.
- WORD_WIDTH, 32, width of an output word; must be an integer multiple of RESULT_DWIDTH (LANES = WORD_WIDTH/RESULT_DWIDTH = 4).
- FIFO_DEPTH, 4, number of word entries in the output FIFO; power of 2, at least 2.
- ADDR_WIDTH, 10, width of the SRAM word address.

Ports:
- clk  in  1  clock; all flops on the rising edge.
- reset_n  in  1  asynchronous reset, active low.
- start  in  1  frame start pulse; loads base_addr and clears all packing and FIFO state.
- base_addr  in  ADDR_WIDTH  first word address of the frame.
- frame_end  in  1  pulse marking the frame end; arrives on or after the cycle of the last result_valid.
- result_data  in  RESULT_DWIDTH  result byte from the datapath.
- result_valid  in  1  result_data qualifier; no backpressure.
- wr_en  out  1  a write is pending.
- wr_addr  out  ADDR_WIDTH  word address of the pending write.
- wr_data  out  WORD_WIDTH  word being written.
- wr_ready  in  1  SRAM accepts the write; a transfer occurs when wr_en & wr_ready.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse when a frame has been fully written.
- fifo_ovrflow  out  1  sticky flag: a packed word was lost.

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-low. reset_n low clears all state at once, independent of clk: state=IDLE, lane=0, FIFO empty, address counter=0, and wr_en, wr_addr, wr_data, busy, done and fifo_ovrflow all 0. Asserting reset_n mid-frame discards everything; no write is completed afterwards.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on start.
  - RUN→FLUSH on frame_end.
  - FLUSH→DONE when the partial word (if any) has been pushed and the FIFO is empty.
  - DONE→IDLE after one cycle; done=1 only in DONE.
- start in any state takes priority over every other event:
  - go to RUN; lane=0; FIFO pointers cleared, discarding pending words; address counter=base_addr; fifo_ovrflow cleared.
  - result_valid on the same cycle as start is ignored.
- result_valid outside RUN is ignored, and so is frame_end outside RUN.
- Packing in RUN:
  - Byte k of a word goes to bits [8k+7:8k], so the first result of the frame is the least significant byte.
  - lane increments on each result_valid.
  - When result_valid arrives with lane=LANES-1, the complete word (including the current byte) is pushed into the FIFO on that edge, and lane wraps to 0.
  - The pack register is not cleared after a push; only lanes written in the current word are used.
- Flush:
  - If result_valid and frame_end arrive together, the byte is packed first, then the flush happens.
  - On entering FLUSH with lane>0, the partial word is pushed on the next edge with unused upper lanes zero, and lane is set to 0.
  - With lane=0 no extra word is pushed.
- FIFO and write port:
  - wr_en = FIFO not empty; wr_data is the FIFO head; wr_addr is the address counter. All three come straight from registers, with no combinational path from inputs.
  - On a transfer the head is popped and the address counter increments, wrapping modulo 2^ADDR_WIDTH.
  - wr_addr and wr_data are held stable while wr_en=1 and wr_ready=0.
  - Latency: a word completed by result_valid at edge t gives wr_en=1 from cycle t+1 if the FIFO was empty.
- Full FIFO:
  - Push and pop on the same edge while full: both happen, and the occupancy stays FIFO_DEPTH.
  - Push while full with no pop: the new word is dropped, fifo_ovrflow is set to 1 and stays set until start or reset.
- busy = (state==RUN) | (state==FLUSH).

Optional Feature:
- Macro RESULT_PACKER_WSTRB_EN.
- Defined:
  - Adds output wr_strb (LANES bits), stored with each FIFO entry and presented with the FIFO head.
  - Full words carry strb=4'b1111; a partial flush word carries ones for filled lanes only (lane=1 gives 4'b0001, lane=3 gives 4'b0111).
  - Zero padding of unused lanes is kept.
- Undefined: no wr_strb port and no strobe storage; every write is a full word with zero-padded unused lanes.

Test Plan:
- Basic packing: reset, start with base_addr=0x010, 8 results 0x01..0x08 back-to-back, wr_ready=1, then frame_end. Expect writes (0x010, 0x04030201) and (0x011, 0x08070605), then a done pulse and busy=0.
- Partial flush: 6 results 0xA0..0xA5, with frame_end on the same cycle as the 6th. Expect the second write to be 0x0000A5A4 at base+1 (wr_strb=4'b0011 when RESULT_PACKER_WSTRB_EN is defined), then done.
- Backpressure and overflow: FIFO_DEPTH=4, wr_ready=0, 24 results. Expect 4 words held, 2 words dropped and fifo_ovrflow=1. Release wr_ready: the 4 words are written in order with wr_addr/wr_data stable while stalled.
- Address wrap: base_addr=0x3FF, 8 results. Expect writes at 0x3FF then 0x000.
- Restart and reset: start mid-frame after 2 full words are buffered, then 4 new results. Expect only the new word to be written, at the new base_addr. Separately, drop reset_n between clock edges mid-frame: all outputs go to 0 at once and no further writes occur.
